// File: rtl/imm_pkg.sv
// imm_pkg: shared types and RV32 opcode constants for the immediate decode pipe.
// The optional Zicsr decode (macro IMM_DEC_ZICSR_EN) uses the FMT_Z code defined here.
package imm_pkg;

    // Immediate format code carried with each decoded entry
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // RV32 major opcodes recognised by the decoder
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_dec_core.sv
// imm_dec_core: purely combinational RV32 immediate decoder, sign-extended to XLEN.
// Define IMM_DEC_ZICSR_EN to decode CSR-immediate forms of SYSTEM as FMT_Z.
module imm_dec_core
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    // Select the format and assemble a 32-bit immediate; the wide result is its sign extension
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
`ifdef IMM_DEC_ZICSR_EN
                // CSR-immediate forms carry a 5-bit unsigned uimm in the rs1 field
                if (instr[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, instr[19:15]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
`else
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // FMT_Z values have bit 31 clear, so a common sign extension also zero-extends them
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: decodes RV32 immediates on the input side and stores them in a
// two-entry skid buffer with a registered in_ready; counts illegal opcodes in err_cnt.
// Macro IMM_DEC_ZICSR_EN (consumed by imm_dec_core) enables the Zicsr FMT_Z decode.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_cnt,
    output logic [15:0]      err_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_dec_core #(
        .XLEN (XLEN)
    ) u_dec (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    buf_state_e state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    entry_t dec_entry;
    logic   push;
    logic   pop;

    // Next-state for the skid buffer and the saturating illegal-opcode counter
    always_comb begin
        dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
        push      = in_valid && in_ready_q;
        pop       = out_valid_q && out_ready;
        state_d   = state_q;
        head_d    = head_q;
        skid_d    = skid_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = dec_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = dec_entry;
                end else if (push) begin
                    skid_d  = dec_entry;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can occur
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Handshake flags are derived from the next state so they are plain flops
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);

        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (push && dec_illegal && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_illegal = head_q.illegal;
    assign out_tag     = head_q.tag;
    assign err_cnt     = err_cnt_q;

endmodule
